// File: rtl/bch_degree_computation.sv
// One Euclidean step of the BCH key-equation solver over GF(2^13).
// Define GF_MUL_REG_EN to register the multiplier sum (latency 4 instead of 3).
module bch_degree_computation #(
  parameter int STOP_DEG = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop_i,
  input  logic [4:0]  deg_Ri,
  input  logic [4:0]  deg_Qi,
  input  logic [12:0] Rin,
  input  logic [12:0] Qin,
  output logic [4:0]  deg_Ro,
  output logic [4:0]  deg_Qo,
  output logic        stop_o,
  output logic        sw,
  output logic [12:0] Rout,
  output logic [12:0] Qout,
  output logic        st_out
);

  localparam logic [5:0] STOP_L = 6'(STOP_DEG);

  function automatic logic [12:0] gf_mul(
    input logic [12:0] a,
    input logic [12:0] b
  );
    logic [12:0] p;
    logic [12:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 13; i++) begin
      if (b[i]) p = p ^ t;
      t = t[12] ? ({t[11:0], 1'b0} ^ 13'h001B)
                : {t[11:0], 1'b0};
    end
    return p;
  endfunction

  logic        stop_q;
  logic [4:0]  d_max;
  logic [4:0]  d_min;
  logic [4:0]  d_new;
  logic        lt;

  always_comb begin
    lt    = deg_Ri < deg_Qi;
    d_max = lt ? deg_Qi : deg_Ri;
    d_min = lt ? deg_Ri : deg_Qi;
    d_new = (d_max == 5'd0) ? 5'd0 : d_max - 5'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw     <= 1'b0;
      deg_Ro <= '0;
      deg_Qo <= '0;
      stop_o <= 1'b0;
      stop_q <= 1'b0;
    end else if (start) begin
      if (stop_i) begin
        sw     <= 1'b0;
        deg_Ro <= deg_Ri;
        deg_Qo <= deg_Qi;
        stop_o <= 1'b1;
        stop_q <= 1'b1;
      end else begin
        sw     <= lt;
        deg_Ro <= d_new;
        deg_Qo <= d_min;
        stop_o <= {1'b0, d_new} < STOP_L;
        stop_q <= 1'b0;
      end
    end
  end

  logic [12:0] r1, q1, r2, q2, r3, q3;
  logic [12:0] lead_r, lead_q;
  logic        s1, s2, s3;
  logic [12:0] r_mux, q_mux;
  logic [12:0] sum;

  assign r_mux = sw ? q1 : r1;
  assign q_mux = sw ? r1 : q1;
  assign sum   = gf_mul(lead_q, r2) ^ gf_mul(lead_r, q2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r1     <= '0;
      q1     <= '0;
      s1     <= 1'b0;
      r2     <= '0;
      q2     <= '0;
      s2     <= 1'b0;
      r3     <= '0;
      q3     <= '0;
      s3     <= 1'b0;
      lead_r <= '0;
      lead_q <= '0;
    end else begin
      r1 <= Rin;
      q1 <= Qin;
      s1 <= start;
      r2 <= r_mux;
      q2 <= q_mux;
      s2 <= s1;
      r3 <= r2;
      q3 <= q2;
      s3 <= s2;
      if (s1) begin
        lead_r <= r_mux;
        lead_q <= q_mux;
      end
    end
  end

`ifdef GF_MUL_REG_EN
  logic [12:0] sum_q, r4, q4;
  logic        s4;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q <= '0;
      r4    <= '0;
      q4    <= '0;
      s4    <= 1'b0;
    end else begin
      sum_q <= sum;
      r4    <= r3;
      q4    <= q3;
      s4    <= s3;
    end
  end

  assign Rout   = stop_q ? r4 : sum_q;
  assign Qout   = q4;
  assign st_out = s4;
`else
  assign Rout   = stop_q ? r3 : sum;
  assign Qout   = q3;
  assign st_out = s3;
`endif

endmodule

// File: tb/tb_bch_degree_computation.sv
// Scoreboard bench for bch_degree_computation: directed two-term streams.
// A monitor pops one expected record on every st_out pulse.
module tb_bch_degree_computation;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stop_i = 1'b0;
  logic [4:0]  deg_Ri = '0;
  logic [4:0]  deg_Qi = '0;
  logic [12:0] Rin = '0;
  logic [12:0] Qin = '0;
  logic [4:0]  deg_Ro, deg_Qo;
  logic        stop_o, sw, st_out;
  logic [12:0] Rout, Qout;

  bch_degree_computation #(.STOP_DEG(8)) dut (
    .clk(clk), .reset(reset), .start(start), .stop_i(stop_i),
    .deg_Ri(deg_Ri), .deg_Qi(deg_Qi), .Rin(Rin), .Qin(Qin),
    .deg_Ro(deg_Ro), .deg_Qo(deg_Qo), .stop_o(stop_o), .sw(sw),
    .Rout(Rout), .Qout(Qout), .st_out(st_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] rout;
    logic [12:0] qout;
    logic [4:0]  dr;
    logic [4:0]  dq;
    logic        sw;
    logic        stop;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (reset && st_out) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_st_out: got 1 expected 0");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("Rout", int'(Rout), int'(e.rout));
        chk("Qout", int'(Qout), int'(e.qout));
        chk("deg_Ro", int'(deg_Ro), int'(e.dr));
        chk("deg_Qo", int'(deg_Qo), int'(e.dq));
        chk("sw", int'(sw), int'(e.sw));
        chk("stop_o", int'(stop_o), int'(e.stop));
      end
    end
  end

  // a,b: leading R/Q terms; r1,q1: next terms
  task automatic send(
    input logic [12:0] a, input logic [12:0] b,
    input logic [12:0] r1, input logic [12:0] q1,
    input logic [4:0] dr, input logic [4:0] dq,
    input logic stp, input exp_t e, input bit track
  );
    @(negedge clk);
    start  = 1'b1;
    stop_i = stp;
    deg_Ri = dr;
    deg_Qi = dq;
    Rin    = a;
    Qin    = b;
    if (track) sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    Rin   = r1;
    Qin   = q1;
    @(negedge clk);
    Rin = '0;
    Qin = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1;
    chk("reset_Rout", int'(Rout), 0);
    chk("reset_Qout", int'(Qout), 0);
    chk("reset_st_out", int'(st_out), 0);
    chk("reset_sw", int'(sw), 0);
    chk("reset_deg_Ro", int'(deg_Ro), 0);
    chk("reset_stop_o", int'(stop_o), 0);
    #20;
    reset = 1'b1;

    // 0x1000*0x0002 = 0x001B
    send(13'h0, 13'h1000, 13'h2, 13'h55, 5'd3, 5'd3, 1'b0,
         '{13'h001B, 13'h1000, 5'd2, 5'd3, 1'b0, 1'b1}, 1'b1);
    idle(3);
    // 0x0001*0x1ABC = 0x1ABC, deg 8 is not below STOP_DEG
    send(13'h0, 13'h1, 13'h1ABC, 13'h77, 5'd9, 5'd9, 1'b0,
         '{13'h1ABC, 13'h0001, 5'd8, 5'd9, 1'b0, 1'b0}, 1'b1);
    idle(3);
    // zero operands, degree saturates at 0
    send(13'h0, 13'h0, 13'h1234, 13'h0ABC, 5'd0, 5'd0, 1'b0,
         '{13'h0000, 13'h0000, 5'd0, 5'd0, 1'b0, 1'b1}, 1'b1);
    idle(3);
    // 1*1 ^ 3*2 = 7
    send(13'h3, 13'h1, 13'h1, 13'h2, 5'd1, 5'd1, 1'b0,
         '{13'h0007, 13'h0001, 5'd0, 5'd1, 1'b0, 1'b1}, 1'b1);
    idle(3);
    // swap: 5*1 ^ 7*1 = 2, Qout = old R lead
    send(13'h5, 13'h7, 13'h1, 13'h1, 5'd10, 5'd12, 1'b0,
         '{13'h0002, 13'h0005, 5'd11, 5'd10, 1'b1, 1'b0}, 1'b1);
    idle(3);
    // 3*4 ^ 2*1 = 0xE
    send(13'h2, 13'h3, 13'h4, 13'h1, 5'd5, 5'd3, 1'b0,
         '{13'h000E, 13'h0003, 5'd4, 5'd3, 1'b0, 1'b1}, 1'b1);
    idle(3);
    // upstream stop: pass-through, degrees unchanged
    send(13'h111, 13'h222, 13'h333, 13'h444, 5'd6, 5'd7, 1'b1,
         '{13'h0111, 13'h0222, 5'd6, 5'd7, 1'b0, 1'b1}, 1'b1);
    idle(3);
    // max degree: 1*2 ^ 1*3 = 1
    send(13'h1, 13'h1, 13'h2, 13'h3, 5'd31, 5'd0, 1'b0,
         '{13'h0001, 13'h0001, 5'd30, 5'd0, 1'b0, 1'b0}, 1'b1);
    idle(3);

    // reset mid-stream
    send(13'h1FFF, 13'h1FFF, 13'h1FFF, 13'h1FFF, 5'd4, 5'd9, 1'b0,
         '{13'h0, 13'h0, 5'd0, 5'd0, 1'b0, 1'b0}, 1'b0);
    reset = 1'b0;
    #1;
    chk("mid_reset_Rout", int'(Rout), 0);
    chk("mid_reset_Qout", int'(Qout), 0);
    chk("mid_reset_st_out", int'(st_out), 0);
    chk("mid_reset_sw", int'(sw), 0);
    chk("mid_reset_deg_Ro", int'(deg_Ro), 0);
    chk("mid_reset_deg_Qo", int'(deg_Qo), 0);
    idle(3);
    reset = 1'b1;
    send(13'h3, 13'h1, 13'h1, 13'h2, 5'd1, 5'd1, 1'b0,
         '{13'h0007, 13'h0001, 5'd0, 5'd1, 1'b0, 1'b1}, 1'b1);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
